// File: rtl/fifo_drain_scheduler.sv
// fifo_drain_scheduler
//
// Round-robin drain engine for a set of count-reporting FIFOs with a
// registered (BRAM-style) read path. One queue is granted at a time for a
// burst of up to MAX_BURST pops. Every popped word is carried through a short
// alignment pipeline and lands in a small first-word-fall-through output
// buffer. Pops are only issued when the buffer is guaranteed to have room, so
// backpressure on the output stream can never cause a popped word to be lost.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   en           allows new grants; a burst already under way always finishes
//   q_count      packed occupancy per source queue (slice i = queue i)
//   q_rd_en      one-hot-or-zero pop strobe per source queue
//   q_rd_data    packed read data per source queue, valid RD_LATENCY after pop
//   out_valid    output buffer holds at least one word
//   out_ready    consumer accepts the head word when out_valid is also high
//   out_data     head word
//   out_src      source queue of the head word
//   out_last     head word was the final pop of its burst
//   busy         bursting, pops in flight, or words still buffered

module fifo_drain_scheduler #(
    parameter int NUM_Q       = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 4,
    parameter int RD_LATENCY  = 1,
    parameter int MAX_BURST   = 4,
    parameter int OUT_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_Q*COUNT_WIDTH-1:0]  q_count,
    output logic [NUM_Q-1:0]              q_rd_en,
    input  logic [NUM_Q*DATA_WIDTH-1:0]   q_rd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_Q)-1:0]      out_src,
    output logic                          out_last,
    output logic                          busy
);

    localparam int QW = $clog2(NUM_Q);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]             state;
    logic [QW-1:0]          grant_id;
    logic [QW-1:0]          rr_last;
    logic [QW-1:0]          rr_pick;
    logic                   rr_found;
    logic [BW-1:0]          burst_cnt;
    logic [COUNT_WIDTH-1:0] grant_count;
    logic                   credit_ok;
    logic                   pop;
    logic                   pop_last;
    int                     search_idx;

    logic [COUNT_WIDTH-1:0] count_arr [NUM_Q];
    logic [DATA_WIDTH-1:0]  data_arr  [NUM_Q];

    logic [RD_LATENCY-1:0]  pipe_valid;
    logic [RD_LATENCY-1:0]  pipe_last;
    logic [QW-1:0]          pipe_src [RD_LATENCY];
    logic [CW-1:0]          inflight;

    logic [DATA_WIDTH-1:0]  buf_data [OUT_DEPTH];
    logic [QW-1:0]          buf_src  [OUT_DEPTH];
    logic                   buf_last [OUT_DEPTH];
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [CW-1:0]          occ;
    logic                   enq;
    logic                   deq;

    // Unpack the flat per-queue buses into arrays so the granted queue and
    // the returning source can be selected by plain indexing.
    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            count_arr[i] = q_count[i*COUNT_WIDTH +: COUNT_WIDTH];
            data_arr[i]  = q_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search: the queue just after the last grant has top
    // priority, wrapping around, so every non-empty queue is eventually served.
    always_comb begin
        rr_found   = 1'b0;
        rr_pick    = '0;
        search_idx = 0;
        for (int k = 1; k <= NUM_Q; k++) begin
            search_idx = (int'(rr_last) + k) % NUM_Q;
            if (!rr_found && count_arr[search_idx] != '0) begin
                rr_found = 1'b1;
                rr_pick  = QW'(search_idx);
            end
        end
    end

    // Words already popped but not yet in the buffer still need a slot, so
    // they count against the buffer's free space. A dequeue in the same cycle
    // is deliberately ignored to keep this path short.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_valid[i]);
        end
    end

    assign occ         = wr_ptr - rd_ptr;
    assign credit_ok   = ({1'b0, occ} + {1'b0, inflight}) < (CW+1)'(OUT_DEPTH);
    assign grant_count = count_arr[grant_id];

    // A pop ends the burst when it empties the queue or hits the burst cap.
    assign pop      = (state == BURST) && (grant_count != '0) && credit_ok;
    assign pop_last = pop && ((grant_count == COUNT_WIDTH'(1)) ||
                              (burst_cnt == BW'(MAX_BURST - 1)));

    always_comb begin
        q_rd_en = '0;
        if (pop) begin
            q_rd_en[grant_id] = 1'b1;
        end
    end

    // Grant FSM. IDLE picks at most one queue per pass, which is what gives
    // the single dead cycle between bursts. In BURST, a credit stall simply
    // holds the state; en is not consulted so a burst always completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_last   <= QW'(NUM_Q - 1);
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && rr_found) begin
                        grant_id  <= rr_pick;
                        rr_last   <= rr_pick;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (pop) begin
                        burst_cnt <= burst_cnt + BW'(1);
                        if (pop_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Alignment pipeline: each pop's tag travels alongside the FIFO's read
    // latency so the tag reaches the last stage exactly when its data does.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_src[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= pop;
            pipe_last[0]  <= pop_last;
            pipe_src[0]   <= grant_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_last[i]  <= pipe_last[i-1];
                pipe_src[i]   <= pipe_src[i-1];
            end
        end
    end

    assign enq = pipe_valid[RD_LATENCY-1];
    assign deq = out_valid && out_ready;

    // Buffer storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            buf_data[wr_ptr[AW-1:0]] <= data_arr[pipe_src[RD_LATENCY-1]];
            buf_src[wr_ptr[AW-1:0]]  <= pipe_src[RD_LATENCY-1];
            buf_last[wr_ptr[AW-1:0]] <= pipe_last[RD_LATENCY-1];
        end
    end

    // Pointers carry an extra MSB so full and empty are distinguishable.
    // Enqueue never sees a full buffer because of the credit check.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Head-word outputs read as zero when the buffer is empty so that stale
    // storage contents never show on the stream.
    assign out_valid = (wr_ptr != rd_ptr);
    assign out_data  = out_valid ? buf_data[rd_ptr[AW-1:0]] : '0;
    assign out_src   = out_valid ? buf_src[rd_ptr[AW-1:0]]  : '0;
    assign out_last  = out_valid ? buf_last[rd_ptr[AW-1:0]] : 1'b0;
    assign busy      = (state == BURST) || (inflight != '0) || out_valid;

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// tb_fifo_drain_scheduler
//
// Directed bench for fifo_drain_scheduler. Four source FIFOs are modelled
// with a one-cycle registered read; queue i returns the word i*64+n for its
// n-th pop ever, so data, source and ordering can all be predicted by hand.
// A monitor logs pops, accepted output words and busy once per cycle.

module tb_fifo_drain_scheduler;

    localparam int NUM_Q       = 4;
    localparam int DATA_WIDTH  = 8;
    localparam int COUNT_WIDTH = 4;
    localparam int RD_LATENCY  = 1;
    localparam int MAX_BURST   = 4;
    localparam int OUT_DEPTH   = 4;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         en;
    logic [NUM_Q*COUNT_WIDTH-1:0] q_count;
    logic [NUM_Q-1:0]             q_rd_en;
    logic [NUM_Q*DATA_WIDTH-1:0]  q_rd_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [1:0]                   out_src;
    logic                         out_last;
    logic                         busy;

    int                    avail  [NUM_Q];
    int                    popped [NUM_Q];
    logic [DATA_WIDTH-1:0] rdata  [NUM_Q];

    int compared = 0;
    int mismatched = 0;
    int illegal = 0;
    int cyc = 0;

    int pop_cyc[$];
    int pop_q[$];
    int w_data[$];
    int w_src[$];
    int w_last[$];
    int w_cyc[$];
    bit busy_log[$];

    fifo_drain_scheduler #(
        .NUM_Q(NUM_Q), .DATA_WIDTH(DATA_WIDTH), .COUNT_WIDTH(COUNT_WIDTH),
        .RD_LATENCY(RD_LATENCY), .MAX_BURST(MAX_BURST), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .q_count(q_count), .q_rd_en(q_rd_en),
        .q_rd_data(q_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Source FIFO occupancy is whatever the bench made available minus what
    // the scheduler has popped so far.
    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            q_count[i*COUNT_WIDTH +: COUNT_WIDTH] = COUNT_WIDTH'(avail[i] - popped[i]);
            q_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rdata[i];
        end
    end

    // Registered read path of each source FIFO.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_Q; i++) begin
            if (q_rd_en[i]) begin
                popped[i] <= popped[i] + 1;
                rdata[i]  <= DATA_WIDTH'(i*64 + popped[i]);
            end
        end
    end

    // Per-cycle monitor, sampled mid-cycle. Also tallies pops that hit an
    // empty queue or strobe more than one queue at once.
    always @(negedge clk) begin
        busy_log.push_back(busy);
        if ($countones(q_rd_en) > 1) illegal++;
        for (int i = 0; i < NUM_Q; i++) begin
            if (q_rd_en[i]) begin
                pop_cyc.push_back(cyc);
                pop_q.push_back(i);
                if (avail[i] - popped[i] <= 0) illegal++;
            end
        end
        if (out_valid && out_ready) begin
            w_data.push_back(int'(out_data));
            w_src.push_back(int'(out_src));
            w_last.push_back(int'(out_last));
            w_cyc.push_back(cyc);
        end
        cyc++;
    end

    // Global watchdog so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Out-of-range reads return -1 so a short log simply shows up as a miss.
    function automatic int wd(int i); return (i < w_data.size()) ? w_data[i] : -1; endfunction
    function automatic int ws(int i); return (i < w_src.size())  ? w_src[i]  : -1; endfunction
    function automatic int wl(int i); return (i < w_last.size()) ? w_last[i] : -1; endfunction
    function automatic int wc(int i); return (i < w_cyc.size())  ? w_cyc[i]  : -1000; endfunction
    function automatic int pc(int i); return (i < pop_cyc.size()) ? pop_cyc[i] : -1000; endfunction
    function automatic int pq(int i); return (i < pop_q.size())   ? pop_q[i]   : -1; endfunction
    function automatic int bl(int i); return (i >= 0 && i < busy_log.size()) ? int'(busy_log[i]) : -1; endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkWord(input string tag, input int idx, input int exp_data,
                             input int exp_src, input int exp_last);
        checkOutput($sformatf("%s_data%0d", tag, idx), wd(idx), exp_data);
        checkOutput($sformatf("%s_src%0d", tag, idx), ws(idx), exp_src);
        checkOutput($sformatf("%s_last%0d", tag, idx), wl(idx), exp_last);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic rdy);
        en = e;
        out_ready = rdy;
    endtask

    task automatic loadQueue(input int q, input int n);
        avail[q] = popped[q] + n;
    endtask

    task automatic applyReset();
        nextCycle();
        for (int i = 0; i < NUM_Q; i++) avail[i] = popped[i];
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 3) checkOutput("idle_timeout", 0, 1);
        nextCycle();
    endtask

    task automatic waitPops(input int target, input int budget);
        int n = 0;
        while (pop_cyc.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (pop_cyc.size() < target) checkOutput("pop_timeout", pop_cyc.size(), target);
    endtask

    initial begin
        int pm, wm, b, rem, bad;
        int base [NUM_Q];

        for (int i = 0; i < NUM_Q; i++) avail[i] = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("rst_rd_en", int'(q_rd_en), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_out_src", int'(out_src), 0);
        checkOutput("rst_out_last", int'(out_last), 0);
        checkOutput("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // Single queue, three words.
        applyStimulus(1'b1, 1'b1);
        pm = pop_cyc.size(); wm = w_data.size(); b = popped[0];
        loadQueue(0, 3);
        waitIdle(60);
        checkOutput("t1_pops", pop_cyc.size() - pm, 3);
        checkOutput("t1_pop_span", pc(pm+2) - pc(pm), 2);
        for (int k = 0; k < 3; k++) checkOutput($sformatf("t1_pop_q%0d", k), pq(pm+k), 0);
        checkOutput("t1_words", w_data.size() - wm, 3);
        for (int k = 0; k < 3; k++) checkWord("t1", wm+k, b+k, 0, (k == 2) ? 1 : 0);
        checkOutput("t1_latency", wc(wm) - pc(pm), RD_LATENCY + 1);
        checkOutput("t1_busy_on_last", bl(wc(wm+2)), 1);
        checkOutput("t1_busy_after", bl(wc(wm+2) + 1), 0);

        // Round-robin fairness: all four queues hold eight words.
        applyReset();
        applyStimulus(1'b1, 1'b1);
        pm = pop_cyc.size(); wm = w_data.size();
        for (int i = 0; i < NUM_Q; i++) begin
            base[i] = popped[i];
            loadQueue(i, 8);
        end
        waitIdle(200);
        checkOutput("t2_words", w_data.size() - wm, 32);
        checkOutput("t2_pops", pop_cyc.size() - pm, 32);
        for (int bb = 0; bb < 8; bb++) begin
            for (int k = 0; k < 4; k++) begin
                checkWord("t2", wm + bb*4 + k, (bb%4)*64 + base[bb%4] + (bb/4)*4 + k,
                          bb % 4, (k == 3) ? 1 : 0);
            end
        end
        checkOutput("t2_dead_cycle", pc(pm+4) - pc(pm+3), 2);
        bad = 0;
        for (int j = 1; j < 32; j++) begin
            if (pc(pm+j) - pc(pm+j-1) != ((j % 4 == 0) ? 2 : 1)) bad++;
        end
        checkOutput("t2_gaps_bad", bad, 0);

        // Backpressure: consumer stalled, queue 2 holds eight words.
        applyReset();
        applyStimulus(1'b1, 1'b0);
        pm = pop_cyc.size(); wm = w_data.size(); b = popped[2];
        loadQueue(2, 8);
        repeat (15) nextCycle();
        checkOutput("t3_stalled_pops", pop_cyc.size() - pm, OUT_DEPTH);
        checkOutput("t3_rd_en_quiet", int'(q_rd_en), 0);
        checkOutput("t3_out_valid", int'(out_valid), 1);
        checkOutput("t3_head_data", int'(out_data), 128 + b);
        checkOutput("t3_head_src", int'(out_src), 2);
        applyStimulus(1'b1, 1'b1);
        waitIdle(100);
        checkOutput("t3_pops", pop_cyc.size() - pm, 8);
        checkOutput("t3_words", w_data.size() - wm, 8);
        for (int k = 0; k < 8; k++) checkWord("t3", wm+k, 128+b+k, 2, (k == 3 || k == 7) ? 1 : 0);

        // Wrap and skip: queue 3 served last, then only queue 1 has data.
        applyReset();
        applyStimulus(1'b1, 1'b1);
        wm = w_data.size(); base[3] = popped[3]; base[1] = popped[1];
        loadQueue(3, 1);
        waitIdle(40);
        loadQueue(1, 2);
        waitIdle(40);
        checkOutput("t4_words", w_data.size() - wm, 3);
        checkWord("t4", wm,   192 + base[3], 3, 1);
        checkWord("t4", wm+1, 64 + base[1],  1, 0);
        checkWord("t4", wm+2, 65 + base[1],  1, 1);

        // en dropped during the second pop of a four-word burst.
        applyReset();
        applyStimulus(1'b1, 1'b1);
        pm = pop_cyc.size(); wm = w_data.size(); b = popped[0];
        loadQueue(0, 8);
        waitPops(pm + 1, 20);
        nextCycle();
        applyStimulus(1'b0, 1'b1);
        waitIdle(60);
        repeat (5) nextCycle();
        checkOutput("t5_pops_gated", pop_cyc.size() - pm, 4);
        checkOutput("t5_words_gated", w_data.size() - wm, 4);
        checkOutput("t5_rd_en_gated", int'(q_rd_en), 0);
        checkOutput("t5_busy_gated", int'(busy), 0);
        checkOutput("t5_last3", wl(wm+3), 1);
        checkOutput("t5_last2", wl(wm+2), 0);
        applyStimulus(1'b1, 1'b1);
        waitIdle(60);
        checkOutput("t5_pops", pop_cyc.size() - pm, 8);
        for (int k = 0; k < 8; k++) checkWord("t5", wm+k, b+k, 0, (k == 3 || k == 7) ? 1 : 0);

        // Reset while pops are in flight.
        applyReset();
        applyStimulus(1'b1, 1'b1);
        pm = pop_cyc.size();
        loadQueue(0, 8);
        waitPops(pm + 2, 20);
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkOutput("t6_rd_en", int'(q_rd_en), 0);
        checkOutput("t6_out_valid", int'(out_valid), 0);
        checkOutput("t6_busy", int'(busy), 0);
        pm = pop_cyc.size(); wm = w_data.size();
        b = popped[0]; rem = avail[0] - popped[0];
        loadQueue(1, 1);
        waitIdle(80);
        checkOutput("t6_first_pop_q", pq(pm), 0);
        checkOutput("t6_first_src", ws(wm), 0);
        checkOutput("t6_first_data", wd(wm), b);
        checkOutput("t6_words", w_data.size() - wm, rem + 1);

        checkOutput("illegal_pops", illegal, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_drain_scheduler.md
Name: fifo_drain_scheduler

Overview:
- Round-robin scheduler that drains NUM_Q count-reporting FIFOs (registered BRAM read path) onto one valid/ready output stream.
- Grants one queue at a time for a burst of up to MAX_BURST pops.
- Issues the queue's rd_en and realigns returned read data after RD_LATENCY cycles.
- Credit-checks every pop against a local output buffer, so no popped word is ever dropped under backpressure.
- Sits between the per-PE result FIFOs and the shared writeback path.

Parameters:
- NUM_Q, 4, number of source FIFOs (>=2).
- DATA_WIDTH, 8, FIFO word width.
- COUNT_WIDTH, 4, width of each FIFO's occupancy count (FIFO DEPTH_WIDTH+1).
- RD_LATENCY, 1, cycles from rd_en high to the valid word on that FIFO's read data (>=1).
- MAX_BURST, 4, maximum pops per grant (>=1).
- OUT_DEPTH, 4, output buffer entries (power of 2, >= RD_LATENCY+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  allow new grants; an in-progress burst always completes
- q_count  in  NUM_Q*COUNT_WIDTH  packed exact occupancy per queue; slice i = queue i
- q_rd_en  out  NUM_Q  one-hot-or-zero pop strobe, one per queue
- q_rd_data  in  NUM_Q*DATA_WIDTH  packed read data per queue
- out_valid  out  1  output buffer non-empty
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  DATA_WIDTH  head word
- out_src  out  clog2(NUM_Q)  source queue of the head word
- out_last  out  1  head word is the final pop of its burst
- busy  out  1  high in BURST, while any pop is in flight, or while out_valid is high

Behaviour:
- Reset values: q_rd_en=0, out_valid=0, out_data=0, out_src=0, out_last=0, busy=0.
- Reset also sets state=IDLE, burst_cnt=0, rr_last=NUM_Q-1 (queue 0 has first priority), and clears the in-flight pipeline and output buffer.
- Reset mid-operation drops all in-flight and buffered words.
- FSM state IDLE:
  - If en and any q_count[i]!=0, grant the first non-empty queue searching rr_last+1, rr_last+2, ... with wrap modulo NUM_Q.
  - On a grant: register grant id, set rr_last=grant, burst_cnt=0, go to BURST.
  - No pop is issued in IDLE.
- FSM state BURST, per cycle:
  - Pop condition: q_count[g]!=0 and credit_ok, where credit_ok = (buffer occupancy + in-flight pops) < OUT_DEPTH.
  - Same-cycle output dequeue is not credited.
  - On a pop: q_rd_en[g]=1 and burst_cnt++.
  - The pop is last if q_count[g]==1 or burst_cnt==MAX_BURST-1. A last pop returns the FSM to IDLE next cycle.
  - No pop (credit stall) keeps the FSM in BURST.
  - An en drop does not end the burst.
  - q_count[g] cannot reach 0 without a last pop, because only this block pops.
- One grant per IDLE pass, so there is exactly one dead cycle between bursts.
- q_rd_en is combinational from registered state and q_count.
- At most one bit of q_rd_en is set, and only in BURST.
- Read alignment:
  - An RD_LATENCY-stage shift pipeline carries {valid, src, last} per pop.
  - At the final stage, capture the q_rd_data slice selected by src into the output buffer with src and last.
- Output buffer:
  - First-word-fall-through, OUT_DEPTH entries, wrapping pointers with an extra MSB.
  - out_valid = not empty.
  - Enqueue and dequeue in the same cycle keep occupancy unchanged.
  - The credit check guarantees enqueue never hits full.
- Throughput: with out_ready held high, one word per cycle within a burst, plus one idle cycle per grant change.
- Ordering: output order equals pop order. Per-queue order is preserved.
- All arithmetic is unsigned.
  - burst_cnt width is clog2(MAX_BURST+1).
  - Occupancy and in-flight counters are clog2(OUT_DEPTH+1) wide.

Test Plan:
- Single queue: q_count[0]=3, others 0, out_ready=1.
  - Required: q_rd_en[0] high for 3 consecutive cycles.
  - Required: words D0,D1,D2 appear in order RD_LATENCY+1 cycles after grant, out_src=0, out_last only on D2, then busy=0.
- Round-robin fairness: all four queues count=8, MAX_BURST=4.
  - Required: grant order 0,1,2,3,0,...; each burst exactly 4 words with out_last on the 4th.
  - Required: one idle cycle between bursts; 32 words total.
- Backpressure: queue 2 count=8, out_ready=0.
  - Required: exactly OUT_DEPTH=4 pops issued, then q_rd_en stays 0.
  - Required: releasing out_ready yields 4 words in order and pops resume; no word lost or duplicated.
- Round-robin wrap and skip: rr_last=3, only queue 1 non-empty (count=2).
  - Required: queue 1 granted next; 2 words, out_last on the 2nd, out_src=1.
- en gating: en dropped on the 2nd pop of a 4-word burst.
  - Required: the burst completes with 4 words; no new grant while en=0; the grant resumes on en=1.
- Reset mid-burst: rst asserted for 1 cycle while pops are in flight.
  - Required: next cycle q_rd_en=0, out_valid=0, busy=0.
  - Required: with queue 0 still non-empty afterwards, queue 0 is granted first.
